// File: rtl/proj_fm_pkg.sv
// Shared sizing helpers for the feature-map stream buffer.
// Holds the bank size computation, the $clog2-based width helpers and the
// chunk-divisibility predicate the top level checks at elaboration.
package proj_fm_pkg;

  // Words held by one bank.
  function automatic int unsigned bank_words(input int unsigned rams,
                                             input int unsigned entries,
                                             input int unsigned offset);
    return rams * entries * offset;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the values 0..banks.
  function automatic int unsigned level_bits(input int unsigned banks);
    return $clog2(banks + 1);
  endfunction

  // True when a bank splits into a whole number of read beats.
  function automatic bit chunk_divides(input int unsigned words,
                                       input int unsigned chunk);
    return (chunk != 0) && ((words % chunk) == 0);
  endfunction

endpackage

// File: rtl/proj_fm_bank_ram.sv
// One buffer bank: single-word synchronous write, CHUNK_SIZE-word read.
// Ports:
//   clk      - clock
//   we       - write enable
//   waddr    - write word address
//   wdata    - write word
//   raddr    - read base address (chunk aligned)
//   rdata_c  - combinational read of raddr..raddr+CHUNK_SIZE-1,
//              lowest address in the MSBs
module proj_fm_bank_ram
  import proj_fm_pkg::*;
#(
  parameter int unsigned WORDS      = 64,
  parameter int unsigned CHUNK_SIZE = 2,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [idx_bits(WORDS)-1:0]          waddr,
  input  logic [DATA_BITS-1:0]                wdata,
  input  logic [idx_bits(WORDS)-1:0]          raddr,
  output logic [CHUNK_SIZE*DATA_BITS-1:0]     rdata_c
);

  localparam int unsigned AW = idx_bits(WORDS);

  logic [DATA_BITS-1:0] mem [WORDS];

  // Storage is intentionally not reset; stale data is never read because
  // a bank only becomes readable after a complete fill.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Chunk assembly: word i of the beat lands in slice CHUNK_SIZE-1-i.
  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < CHUNK_SIZE; i++) begin
      rdata_c[(CHUNK_SIZE-1-i)*DATA_BITS +: DATA_BITS] = mem[raddr + AW'(i)];
    end
  end

endmodule

// File: rtl/proj_fm_stream_buf.sv
// N-bank feature-map stream buffer with valid/ready on both sides.
// Words fill banks in rotation; a full bank is streamed out as
// CHUNK_SIZE-word beats, READ_PASSES times, then released.
// Ports:
//   in_clk, in_rst_n       - clock, synchronous active-low reset
//   in_wdata/in_wvalid     - write word stream
//   out_wready             - combinational: a bank has free space
//   out_rdata/out_rvalid   - registered read beat
//   in_rready              - consumer accepts the beat
//   out_rlast              - beat is the last chunk of a pass
//   out_level              - number of full, unreleased banks
module proj_fm_stream_buf
  import proj_fm_pkg::*;
#(
  parameter int unsigned BUFFER_COUNT = 2,
  parameter int unsigned RAMS         = 2,
  parameter int unsigned ENTRIES      = 4,
  parameter int unsigned OFFSET       = 8,
  parameter int unsigned CHUNK_SIZE   = 2,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned READ_PASSES  = 1
) (
  input  logic                                   in_clk,
  input  logic                                   in_rst_n,
  input  logic [DATA_BITS-1:0]                   in_wdata,
  input  logic                                   in_wvalid,
  output logic                                   out_wready,
  output logic [CHUNK_SIZE*DATA_BITS-1:0]        out_rdata,
  output logic                                   out_rvalid,
  input  logic                                   in_rready,
  output logic                                   out_rlast,
  output logic [level_bits(BUFFER_COUNT)-1:0]    out_level
);

  localparam int unsigned BANK_WORDS = bank_words(RAMS, ENTRIES, OFFSET);
  localparam int unsigned AW         = idx_bits(BANK_WORDS);
  localparam int unsigned BW         = idx_bits(BUFFER_COUNT);
  localparam int unsigned LW         = level_bits(BUFFER_COUNT);
  localparam int unsigned PW         = idx_bits(READ_PASSES);
  localparam int unsigned RW         = CHUNK_SIZE * DATA_BITS;

  // Elaboration-time parameter sanity.
  if (!chunk_divides(BANK_WORDS, CHUNK_SIZE)) begin : g_bad_chunk
    $error("proj_fm_stream_buf: CHUNK_SIZE must divide BANK_WORDS");
  end
  if (BUFFER_COUNT < 2) begin : g_bad_banks
    $error("proj_fm_stream_buf: BUFFER_COUNT must be at least 2");
  end
  if (READ_PASSES < 1) begin : g_bad_passes
    $error("proj_fm_stream_buf: READ_PASSES must be at least 1");
  end

  // Registered state
  logic [AW-1:0] wr_addr, rd_addr;
  logic [BW-1:0] wr_bank, rd_bank;
  logic [PW-1:0] pass_cnt;
  logic [LW-1:0] occupancy;
  logic [RW-1:0] rdata_q;
  logic          rvalid_q, rlast_q;

  // Next-state values
  logic [AW-1:0] wr_addr_d, rd_addr_d;
  logic [BW-1:0] wr_bank_d, rd_bank_d;
  logic [PW-1:0] pass_cnt_d;
  logic [LW-1:0] occupancy_d;
  logic [RW-1:0] rdata_d;
  logic          rvalid_d, rlast_d;

  // Per-cycle events
  logic          wr_fire_c, bank_fill_c, fetch_c, last_chunk_c, pass_end_c,
                 bank_release_c;
  logic [RW-1:0] rd_mux_c;
  logic [RW-1:0] bank_rdata [BUFFER_COUNT];

  assign out_wready = (occupancy < LW'(BUFFER_COUNT));

  // Bank array; each bank only sees writes aimed at it.
  for (genvar b = 0; b < BUFFER_COUNT; b++) begin : g_bank
    proj_fm_bank_ram #(
      .WORDS      (BANK_WORDS),
      .CHUNK_SIZE (CHUNK_SIZE),
      .DATA_BITS  (DATA_BITS)
    ) u_ram (
      .clk     (in_clk),
      .we      (wr_fire_c && (wr_bank == BW'(b))),
      .waddr   (wr_addr),
      .wdata   (in_wdata),
      .raddr   (rd_addr),
      .rdata_c (bank_rdata[b])
    );
  end

  // Read-side bank select.
  always_comb begin
    rd_mux_c = '0;
    for (int b = 0; b < BUFFER_COUNT; b++) begin
      if (rd_bank == BW'(b)) begin
        rd_mux_c = bank_rdata[b];
      end
    end
  end

  // Handshake and bank life-cycle events.
  always_comb begin
    wr_fire_c      = in_wvalid && out_wready;
    bank_fill_c    = wr_fire_c && (wr_addr == AW'(BANK_WORDS - 1));
    // The output stage may refill when empty or when its beat is taken.
    fetch_c        = (occupancy != '0) && (!rvalid_q || in_rready);
    last_chunk_c   = (rd_addr == AW'(BANK_WORDS - CHUNK_SIZE));
    pass_end_c     = fetch_c && last_chunk_c;
    bank_release_c = pass_end_c && (pass_cnt == PW'(READ_PASSES - 1));
  end

  // Next-state logic for counters, occupancy and the output stage.
  always_comb begin
    wr_addr_d   = wr_addr;
    wr_bank_d   = wr_bank;
    rd_addr_d   = rd_addr;
    rd_bank_d   = rd_bank;
    pass_cnt_d  = pass_cnt;
    occupancy_d = occupancy;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;

    if (wr_fire_c) begin
      if (bank_fill_c) begin
        wr_addr_d = '0;
        wr_bank_d = (wr_bank == BW'(BUFFER_COUNT - 1)) ? '0 : wr_bank + BW'(1);
      end else begin
        wr_addr_d = wr_addr + AW'(1);
      end
    end

    if (fetch_c) begin
      rdata_d  = rd_mux_c;
      rvalid_d = 1'b1;
      rlast_d  = last_chunk_c;
      if (pass_end_c) begin
        rd_addr_d = '0;
        if (bank_release_c) begin
          pass_cnt_d = '0;
          rd_bank_d  = (rd_bank == BW'(BUFFER_COUNT - 1)) ? '0 : rd_bank + BW'(1);
        end else begin
          pass_cnt_d = pass_cnt + PW'(1);
        end
      end else begin
        rd_addr_d = rd_addr + AW'(CHUNK_SIZE);
      end
    end else if (in_rready) begin
      rvalid_d = 1'b0;
    end

    // A fill and a release on the same edge cancel out.
    unique case ({bank_fill_c, bank_release_c})
      2'b10:   occupancy_d = occupancy + LW'(1);
      2'b01:   occupancy_d = occupancy - LW'(1);
      default: occupancy_d = occupancy;
    endcase
  end

  // State registers with synchronous reset; partial frames are discarded.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      wr_addr   <= '0;
      wr_bank   <= '0;
      rd_addr   <= '0;
      rd_bank   <= '0;
      pass_cnt  <= '0;
      occupancy <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      wr_addr   <= wr_addr_d;
      wr_bank   <= wr_bank_d;
      rd_addr   <= rd_addr_d;
      rd_bank   <= rd_bank_d;
      pass_cnt  <= pass_cnt_d;
      occupancy <= occupancy_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  assign out_rdata  = rdata_q;
  assign out_rvalid = rvalid_q;
  assign out_rlast  = rlast_q;
  assign out_level  = occupancy;

endmodule

// File: doc/proj_fm_stream_buf.md
# proj_fm_stream_buf

Parametrised N-bank feature-map buffer with valid/ready flow control on both sides. Words stream in one per cycle and fill banks in rotation. A bank becomes readable only once it is full, and is then streamed out as CHUNK_SIZE-word beats, optionally replayed READ_PASSES times before it is released. The block sits between the feature-map producer and the MinHash projection datapath, and replaces fixed two-bank free-running buffering with backpressure-safe, occupancy-tracked buffering.

## Interface
- BUFFER_COUNT, 2: number of banks (≥2).
- RAMS, 2: RAMs per bank.
- ENTRIES, 4: entries per RAM.
- OFFSET, 8: words per entry.
- CHUNK_SIZE, 2: words per read beat; must divide BANK_WORDS = RAMS*ENTRIES*OFFSET.
- DATA_BITS, 8: word width.
- READ_PASSES, 1: full read passes per bank before release (≥1).
- in_clk  in  1  clock; single clock domain.
- in_rst_n  in  1  reset; synchronous, active-low.
- in_wdata  in  DATA_BITS  write word.
- in_wvalid  in  1  write word valid.
- out_wready  out  1  a bank has free space; = (occupancy < BUFFER_COUNT).
- out_rdata  out  CHUNK_SIZE*DATA_BITS  read chunk; lowest-address word in the MSBs.
- out_rvalid  out  1  out_rdata valid.
- in_rready  in  1  consumer accepts the beat.
- out_rlast  out  1  beat is the last chunk of a pass.
- out_level  out  $clog2(BUFFER_COUNT+1)  number of full, unreleased banks.

## Operation
- Write handshake: in_wvalid && out_wready. Word goes to bank wr_bank at address wr_addr; wr_addr increments.
- At wr_addr == BANK_WORDS-1 with a handshake: wr_addr wraps to 0, wr_bank advances modulo BUFFER_COUNT, occupancy increments.
- Read fetch is enabled when occupancy > 0 and the output stage is free or drained: (!out_rvalid || in_rready).
- On each fetch:
  - Reads words rd_addr .. rd_addr+CHUNK_SIZE-1 of rd_bank into the output register and sets out_rvalid.
  - rd_addr += CHUNK_SIZE.
  - out_rlast is registered as 1 when rd_addr == BANK_WORDS-CHUNK_SIZE.
- End of a pass: rd_addr wraps to 0 and pass_cnt increments.
- On the fetch of the last chunk of pass READ_PASSES-1: pass_cnt clears, rd_bank advances modulo BUFFER_COUNT, occupancy decrements.
- A beat completes on out_rvalid && in_rready. If no new fetch occurs that cycle, out_rvalid clears.
- out_rdata and out_rlast hold stable while out_rvalid && !in_rready.
- Bank fill and bank release on the same edge: occupancy unchanged. Writes into a bank may proceed during reads of another bank.
- Full (occupancy == BUFFER_COUNT): out_wready = 0; input words are neither written nor lost.
- Empty (occupancy == 0): no fetch. out_rvalid drops once the held beat is consumed.
- Reset (any cycle, mid-frame included):
  - Clears wr_addr, rd_addr, wr_bank, rd_bank, pass_cnt and occupancy.
  - out_rvalid = 0, out_rlast = 0, out_rdata = 0, out_level = 0.
  - Partial frames are discarded. Bank RAM contents are not cleared.

## Timing
- Write: word is stored on the handshake edge. occupancy and out_level update on the same edge as the last word of a bank.
- Read latency:
  - Minimum 2 edges from the last-word write handshake to out_rvalid high: edge 1 fills the bank, edge 2 fetches.
  - Back-to-back beats at 1 per cycle while in_rready = 1.
- Steady-state throughput: 1 word/cycle in; CHUNK_SIZE words/cycle out. Reads stall writes only through occupancy.
- out_wready is combinational from registered occupancy; it is 1 on the first cycle after reset.
- All other outputs are registered.

## Structure
- Shared package proj_fm_pkg holds:
  - the BANK_WORDS computation;
  - address, bank-index and level width functions ($clog2-based);
  - the elaboration-time check CHUNK_SIZE divides BANK_WORDS.
- Sub-module proj_fm_bank_ram: one bank with a 1-word synchronous write port and a CHUNK_SIZE-word read port. Instantiate it BUFFER_COUNT times with a generate loop and mux reads by rd_bank.
- Top level contains the write/read counters, the occupancy counter and the output register stage.

## Test plan
All scenarios use default parameters: BANK_WORDS = 64, 32 beats per bank.
- Stream words 0..63, in_rready = 1 → 32 beats. First beat 16'h0001, last beat 16'h3E3F with out_rlast = 1. out_level goes 0→1→0.
- Write 128 words with in_rready = 0 → out_wready = 0 after word 127 and out_level = 2. Word 128 is held with no overwrite. With in_rready then set to 1, bank 0 data (16'h0001 first) emerges before bank 1 data.
- Hold in_rready = 0 for 5 cycles mid-bank → out_rdata is stable, and no beat is skipped or duplicated after release.
- READ_PASSES = 2 → each bank is emitted twice (64 beats) with two out_rlast pulses. out_level decrements only after the second pass.
- Bank fill and bank release on the same edge → out_level is unchanged and the next bank is read seamlessly.
- Assert in_rst_n = 0 at write word 40 and at read beat 10 → all outputs are 0 the next cycle and out_wready = 1. A fresh 64-word frame reads back correctly.
